// File: rtl/fifo_arb_pkg.sv
// Shared defaults, FSM state type and width helper for the FIFO write arbiter.
package fifo_arb_pkg;

    localparam int unsigned DefNreq     = 4;
    localparam int unsigned DefDw       = 16;
    localparam int unsigned DefDepth    = 32;
    localparam int unsigned DefMaxBurst = 4;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StBurst = 1'b1
    } arb_state_e;

    // Index width that never collapses to zero bits (a single-value counter still needs one).
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating-priority search: first set bit of req at or above ptr, wrapping.
module rr_picker import fifo_arb_pkg::*; #(
    parameter int unsigned NREQ = DefNreq,
    parameter int unsigned PW   = clog2_min1(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            found,
    output logic [PW-1:0]   idx
);

    logic [PW-1:0] cand;

    // Walk offsets from the far end so the hit nearest to ptr is the one left standing.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int off = int'(NREQ) - 1; off >= 0; off--) begin
            cand = PW'((int'(ptr) + off) % int'(NREQ));
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding the write side of a shared synchronous FIFO.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
    parameter int unsigned NREQ      = DefNreq,
    parameter int unsigned DW        = DefDw,
    parameter int unsigned DEPTH     = DefDepth,
    parameter int unsigned MAX_BURST = DefMaxBurst,
    parameter int unsigned CW        = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DW-1:0]       req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic [CW-1:0]            fifo_cnt,
    output logic                     fifo_wr,
    output logic [DW-1:0]            fifo_data,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy
);

    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned BW = clog2_min1(MAX_BURST);

    localparam int unsigned LastBeatInt = MAX_BURST - 1;
    localparam int unsigned LastReqInt  = NREQ - 1;

    localparam logic [BW-1:0] LastBeat = LastBeatInt[BW-1:0];
    localparam logic [PW-1:0] LastReq  = LastReqInt[PW-1:0];
    localparam logic [CW:0]   DepthCmp = DEPTH[CW:0];

    arb_state_e    state_q, state_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] grant_id_q, grant_id_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic          fifo_wr_q, fifo_wr_d;
    logic [DW-1:0] fifo_data_q, fifo_data_d;

    logic          pick_found;
    logic [PW-1:0] pick_idx;
    logic [CW:0]   occupancy;
    logic          space_ok;
    logic          xfer;
    logic [DW-1:0] cur_data;
    logic [PW-1:0] next_ptr;

    rr_picker #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // A write already scheduled in fifo_wr_q has not reached fifo_cnt yet, so count it as used.
    assign occupancy = {1'b0, fifo_cnt} + {{CW{1'b0}}, fifo_wr_q};
    assign space_ok  = occupancy < DepthCmp;

    assign cur_data = req_data[grant_id_q * DW +: DW];
    assign xfer     = (state_q == StBurst) && req_valid[grant_id_q] && space_ok;
    assign next_ptr = (grant_id_q == LastReq) ? '0 : grant_id_q + 1'b1;

    // Ready goes only to the current grantee and only while the FIFO can take another word.
    always_comb begin
        req_ready = '0;
        if (state_q == StBurst && space_ok) begin
            req_ready[grant_id_q] = 1'b1;
        end
    end

    // Grant selection, beat counting, release and the registered FIFO write port.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        beat_cnt_d  = beat_cnt_q;
        fifo_wr_d   = 1'b0;
        fifo_data_d = fifo_data_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_id_d = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = StBurst;
                end
            end
            StBurst: begin
                if (!req_valid[grant_id_q]) begin
                    // Grantee withdrew; nothing transferred this edge.
                    state_d  = StIdle;
                    rr_ptr_d = next_ptr;
                end else if (xfer) begin
                    fifo_wr_d   = 1'b1;
                    fifo_data_d = cur_data;
                    if (beat_cnt_q == LastBeat) begin
                        state_d  = StIdle;
                        rr_ptr_d = next_ptr;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
                // Otherwise stalled on full: hold grant and beat count.
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset also drops any write scheduled for the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            beat_cnt_q  <= '0;
            fifo_wr_q   <= 1'b0;
            fifo_data_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            beat_cnt_q  <= beat_cnt_d;
            fifo_wr_q   <= fifo_wr_d;
            fifo_data_q <= fifo_data_d;
        end
    end

    assign fifo_wr   = fifo_wr_q;
    assign fifo_data = fifo_data_q;
    assign grant_id  = grant_id_q;
    assign busy      = (state_q == StBurst);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table plus multi-cycle corner sequences.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [63:0] req_data = '0;
    logic [3:0]  req_ready;
    logic [5:0]  fifo_cnt = '0;
    logic        fifo_wr;
    logic [15:0] fifo_data;
    logic [1:0]  grant_id;
    logic        busy;

    int checks = 0;
    int failures = 0;

    logic       model_en = 1'b0;
    logic       fifo_rd = 1'b0;
    logic [3:0] last_xfer = '0;
    logic [3:0] rdy_pre = '0;
    int         occ_pre = 0;
    int         sent[4];

    typedef struct packed {
        logic [3:0]  valid;
        logic [15:0] data;
        logic [5:0]  cnt;
        logic [3:0]  exp_ready;
        logic        exp_wr;
        logic [15:0] exp_data;
        logic [1:0]  exp_grant;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[$];

    fifo_wr_arbiter #(
        .NREQ      (4),
        .DW        (16),
        .DEPTH     (32),
        .MAX_BURST (4),
        .CW        (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_cnt  (fifo_cnt),
        .fifo_wr   (fifo_wr),
        .fifo_data (fifo_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vec_t mk(input logic [3:0] v, input logic [15:0] d, input logic [5:0] c,
                                input logic [3:0] er, input logic ew, input logic [15:0] ed,
                                input logic [1:0] eg, input logic eb);
        vec_t t;
        t.valid = v; t.data = d; t.cnt = c;
        t.exp_ready = er; t.exp_wr = ew; t.exp_data = ed; t.exp_grant = eg; t.exp_busy = eb;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sample handshake state at the negedge, advance one rising edge, then update the FIFO model.
    task automatic tick();
        logic       wr_pre;
        logic [3:0] x;
        @(negedge clk);
        wr_pre  = fifo_wr;
        x       = req_ready & req_valid;
        rdy_pre = req_ready;
        occ_pre = int'(fifo_cnt) + int'(wr_pre);
        @(posedge clk);
        last_xfer = x;
        #1;
        if (model_en) fifo_cnt = fifo_cnt + {5'd0, wr_pre} - {5'd0, fifo_rd};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        fifo_rd = 1'b0;
        model_en = 1'b0;
        fifo_cnt = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic lane_data(input logic [7:0] base3, input logic [7:0] base1);
        req_data[15:0]  = 16'(sent[0]);
        req_data[31:16] = {base1, 8'(sent[1])};
        req_data[47:32] = 16'h0200 + 16'(sent[2]);
        req_data[63:48] = {base3, 8'(sent[3])};
    endtask

    initial begin
        int wr_count;
        int bad_ready;
        int b;
        int k;
        int g;

        // Reset values
        #1 rst = 1'b1;
        req_valid = 4'hF;
        #1;
        chk("rst_wr", fifo_wr, 0);
        chk("rst_data", fifo_data, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        req_valid = '0;
        tick();
        rst = 1'b0;

        // Vector table: single requester, burst cap, re-grant, full boundary
        vecs.push_back(mk(4'b0100, 16'h000A, 6'd0,  4'b0000, 1'b0, 16'h0000, 2'd2, 1'b1));
        vecs.push_back(mk(4'b0100, 16'h000A, 6'd0,  4'b0100, 1'b1, 16'h000A, 2'd2, 1'b1));
        vecs.push_back(mk(4'b0100, 16'h000B, 6'd0,  4'b0100, 1'b1, 16'h000B, 2'd2, 1'b1));
        vecs.push_back(mk(4'b0100, 16'h000C, 6'd0,  4'b0100, 1'b1, 16'h000C, 2'd2, 1'b1));
        vecs.push_back(mk(4'b0000, 16'h000C, 6'd0,  4'b0100, 1'b0, 16'h000C, 2'd2, 1'b0));
        vecs.push_back(mk(4'b0000, 16'h000C, 6'd0,  4'b0000, 1'b0, 16'h000C, 2'd2, 1'b0));
        vecs.push_back(mk(4'b1000, 16'h0031, 6'd0,  4'b0000, 1'b0, 16'h000C, 2'd3, 1'b1));
        vecs.push_back(mk(4'b1000, 16'h0031, 6'd0,  4'b1000, 1'b1, 16'h0031, 2'd3, 1'b1));
        vecs.push_back(mk(4'b1000, 16'h0032, 6'd0,  4'b1000, 1'b1, 16'h0032, 2'd3, 1'b1));
        vecs.push_back(mk(4'b1000, 16'h0033, 6'd0,  4'b1000, 1'b1, 16'h0033, 2'd3, 1'b1));
        vecs.push_back(mk(4'b1000, 16'h0034, 6'd0,  4'b1000, 1'b1, 16'h0034, 2'd3, 1'b0));
        vecs.push_back(mk(4'b1000, 16'h0035, 6'd0,  4'b0000, 1'b0, 16'h0034, 2'd3, 1'b1));
        vecs.push_back(mk(4'b0000, 16'h0035, 6'd0,  4'b1000, 1'b0, 16'h0034, 2'd3, 1'b0));
        vecs.push_back(mk(4'b0001, 16'h0050, 6'd31, 4'b0000, 1'b0, 16'h0034, 2'd0, 1'b1));
        vecs.push_back(mk(4'b0001, 16'h0050, 6'd31, 4'b0001, 1'b1, 16'h0050, 2'd0, 1'b1));
        vecs.push_back(mk(4'b0001, 16'h0051, 6'd31, 4'b0000, 1'b0, 16'h0050, 2'd0, 1'b1));
        vecs.push_back(mk(4'b0001, 16'h0051, 6'd32, 4'b0000, 1'b0, 16'h0050, 2'd0, 1'b1));
        vecs.push_back(mk(4'b0001, 16'h0051, 6'd30, 4'b0001, 1'b1, 16'h0051, 2'd0, 1'b1));
        vecs.push_back(mk(4'b0000, 16'h0051, 6'd0,  4'b0001, 1'b0, 16'h0051, 2'd0, 1'b0));

        foreach (vecs[r]) begin
            req_valid = vecs[r].valid;
            req_data  = {4{vecs[r].data}};
            fifo_cnt  = vecs[r].cnt;
            tick();
            chk($sformatf("vec%0d_ready", r), rdy_pre, vecs[r].exp_ready);
            chk($sformatf("vec%0d_wr", r), fifo_wr, vecs[r].exp_wr);
            chk($sformatf("vec%0d_data", r), fifo_data, vecs[r].exp_data);
            chk($sformatf("vec%0d_grant", r), grant_id, vecs[r].exp_grant);
            chk($sformatf("vec%0d_busy", r), busy, vecs[r].exp_busy);
        end

        // Round-robin: all four valid, 4-beat bursts, one idle cycle between grants
        do_reset();
        for (int i = 0; i < 4; i++) sent[i] = 0;
        lane_data(8'h03, 8'h01);
        req_valid = 4'hF;
        for (int e = 1; e <= 21; e++) begin
            tick();
            for (int i = 0; i < 4; i++) if (last_xfer[i]) sent[i]++;
            lane_data(8'h03, 8'h01);
            chk($sformatf("rr%0d_wr", e), fifo_wr, (e % 5 != 1));
            chk($sformatf("rr%0d_busy", e), busy, (e % 5 != 0));
            chk($sformatf("rr%0d_grant", e), grant_id, ((e - 1) / 5) % 4);
            if (e % 5 != 1) begin
                b = (e - 2) / 5;
                k = (e - 2) % 5;
                g = b % 4;
                if (g == 0)      chk($sformatf("rr%0d_data", e), fifo_data, 16'(4 * (b / 4) + k));
                else if (g == 2) chk($sformatf("rr%0d_data", e), fifo_data, 16'h0200 + 16'(k));
                else             chk($sformatf("rr%0d_data", e), fifo_data, {8'(g), 8'(k)});
            end
        end

        // Full stall: FIFO model counts writes, no reads; requester 0 streams up to 40 words
        do_reset();
        model_en = 1'b1;
        for (int i = 0; i < 4; i++) sent[i] = 0;
        lane_data(8'h03, 8'h01);
        req_valid = 4'b0001;
        wr_count = 0;
        bad_ready = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (occ_pre >= 32 && rdy_pre != 4'b0000) bad_ready++;
            if (last_xfer[0]) sent[0]++;
            req_valid[0] = (sent[0] < 40);
            lane_data(8'h03, 8'h01);
            if (fifo_wr) begin
                chk($sformatf("stall_data%0d", wr_count), fifo_data, 16'(wr_count));
                wr_count++;
            end
        end
        chk("stall_writes", wr_count, 32);
        chk("stall_cnt", fifo_cnt, 32);
        chk("stall_ready_when_full", bad_ready, 0);
        chk("stall_ready_last", rdy_pre, 4'b0000);
        chk("stall_busy", busy, 1);
        chk("stall_grant", grant_id, 0);
        fifo_rd = 1'b1;
        tick();
        fifo_rd = 1'b0;
        if (fifo_wr) wr_count++;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (last_xfer[0]) sent[0]++;
            lane_data(8'h03, 8'h01);
            if (fifo_wr) begin
                chk("stall_extra_data", fifo_data, 16'd32);
                wr_count++;
            end
        end
        chk("stall_after_read", wr_count, 33);
        chk("stall_cnt_after_read", fifo_cnt, 32);

        // Early release: req1 gives two beats then drops; rr_ptr must land on 2
        do_reset();
        for (int i = 0; i < 4; i++) sent[i] = 0;
        lane_data(8'h33, 8'h11);
        req_valid = 4'b1010;
        tick();
        chk("er_grant1", grant_id, 1);
        chk("er_busy1", busy, 1);
        tick();
        if (last_xfer[1]) sent[1]++;
        lane_data(8'h33, 8'h11);
        chk("er_wr_b0", fifo_wr, 1);
        chk("er_data_b0", fifo_data, 16'h1100);
        tick();
        if (last_xfer[1]) sent[1]++;
        lane_data(8'h33, 8'h11);
        chk("er_wr_b1", fifo_wr, 1);
        chk("er_data_b1", fifo_data, 16'h1101);
        req_valid = 4'b1001;
        tick();
        chk("er_release_busy", busy, 0);
        chk("er_release_wr", fifo_wr, 0);
        tick();
        chk("er_next_grant", grant_id, 3);
        chk("er_next_busy", busy, 1);
        tick();
        chk("er_req3_wr", fifo_wr, 1);
        chk("er_req3_data", fifo_data, 16'h3300);

        // Asynchronous reset between edges while a write is scheduled
        #2 rst = 1'b1;
        #1;
        chk("ar_wr", fifo_wr, 0);
        chk("ar_ready", req_ready, 0);
        chk("ar_busy", busy, 0);
        chk("ar_grant", grant_id, 0);
        #2 rst = 1'b0;
        tick();
        chk("ar_first_grant", grant_id, 0);
        chk("ar_first_busy", busy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
